hydra_pkt_gen: RTL and testbench
================================

# hydra_pkt_gen

Parametrised, synthesizable multi-port packet traffic generator for the hydra switch ingress interface. One independent lane per ingress port produces sop/header/data/eop sequences. Packets have fixed or LFSR-random length, destination and priority, a programmable inter-packet gap, and an optional per-port packet quota. It replaces hand-written stimulus and can also drive hydra directly in on-chip self-test.

## Interface
Parameters:
- NUM_PORTS, 16: number of lanes / ingress ports (1..16).
- DATA_W, 16: word width; must be ≥16.
- LEN_MIN, 32: minimum payload length in words, random mode.
- LEN_SPAN_LOG2, 6: random length range is LEN_MIN .. LEN_MIN+2^LEN_SPAN_LOG2−1; LEN_MIN+span−1 ≤ 511.
- SEED, 16'hACE1: base LFSR seed; lane p seeds with SEED ^ (p+1), forced to 1 if the result is 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  global run. Lanes start new packets only while high.
- port_mask  in  NUM_PORTS  per-lane enable.
- len_mode  in  1  0 = fixed cfg_len, 1 = random.
- cfg_len  in  9  fixed payload length in words; 0 is treated as 1.
- dest_mode  in  1  0 = fixed cfg_dest, 1 = random.
- cfg_dest  in  4  fixed destination port.
- cfg_prio  in  3  fixed priority, used when dest_mode = 0.
- cfg_gap  in  4  idle cycles after eop.
- cfg_pkt_num  in  16  packets per lane; 0 = unlimited.
- wr_sop  out  NUM_PORTS  start-of-packet pulse.
- wr_eop  out  NUM_PORTS  end-of-packet pulse.
- wr_vld  out  NUM_PORTS  word valid.
- wr_data  out  NUM_PORTS×DATA_W  packed word per lane.
- done  out  NUM_PORTS  lane has sent cfg_pkt_num packets.

## Operation
- Per-lane FSM states: IDLE, SOP, HDR, DATA, EOP, GAP.
- IDLE → SOP when enable & port_mask[p] & !done[p]; otherwise stay in IDLE.
- SOP: wr_sop=1 for one cycle. The LFSR advances once. len/dest/prio/gap are latched into per-packet registers. Later config changes do not affect an in-flight packet.
- SOP → HDR. HDR: wr_vld=1; wr_data = {zero-extend, len[8:0] at [15:7], prio at [6:4], dest at [3:0]}.
- Random fields, taken from the post-advance LFSR value L:
  - len = LEN_MIN + (L[15:8] masked to LEN_SPAN_LOG2 bits).
  - dest = L[3:0] mod NUM_PORTS, by masking when NUM_PORTS is a power of two, else by compare-subtract.
  - prio = L[6:4].
- DATA: wr_vld=1 for exactly len cycles. Word i (0-based) = {p[3:0] in bits [DATA_W−1:DATA_W−4], i in the low bits, zero elsewhere}.
- DATA → EOP after word len−1. EOP: wr_eop=1, wr_vld=0, one cycle. The sent counter increments.
- EOP → GAP if the latched gap > 0, else → IDLE. GAP lasts exactly gap cycles, then → IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
- done[p] is set in the EOP cycle when sent+1 == cfg_pkt_num (cfg_pkt_num ≠ 0). done is sticky until reset. Sent counter saturates at 16'hFFFF.
- Deasserting enable or port_mask[p] mid-packet does not truncate the packet. The lane completes through EOP/GAP, then holds in IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0; wr_data is 0 whenever wr_vld=0.
- If IDLE sees the start condition at edge t: sop at t+1, header at t+2, data t+3..t+2+len, eop at t+3+len.
- Minimum sop-to-sop spacing = len + 4 + gap cycles.
- wr_sop, wr_vld and wr_eop are mutually exclusive within a lane.
- Lanes are fully independent and may be simultaneously active.
- Reset asserted mid-packet: outputs go to 0 immediately (asynchronous), state → IDLE, LFSR reseeded, sent and done cleared.

## Structure
- Package hydra_pkg holds:
  - the lane state enum;
  - header field positions (LEN_LSB=7, PRIO_LSB=4, DEST_LSB=0);
  - the LFSR tap constant and a next-LFSR function.
- Sub-module hydra_pkt_gen_lane implements one lane's FSM, LFSR and counters.
- The top instantiates NUM_PORTS lanes with a generate loop and packs their outputs.

## Test plan
- Fixed mode, cfg_len=32, cfg_dest=5, cfg_prio=3, gap=0, lane 0 only:
  - header = 16'h1035; 32 data words 0x0000..0x001F; eop one cycle after the last vld; sop-to-sop spacing 36.
- cfg_pkt_num=3, all 16 lanes:
  - exactly 3 sop/eop pairs per lane; done = 16'hFFFF after the third eop; no further sop while enable stays high.
- Random mode, default parameters, 200 packets:
  - every len in 32..95; dest < NUM_PORTS; each header's length field equals the counted vld words − 1.
- enable dropped two cycles after sop, len=40:
  - packet completes with 40 data words and eop; no new sop until enable returns.
- rst_n pulsed low mid-DATA:
  - wr_vld/wr_data/wr_sop/wr_eop read 0 within the same cycle; after release, the first packet header matches the first post-seed LFSR value.
- cfg_gap=7, len_mode=0, cfg_len=0:
  - 1 data word per packet; exactly 7 idle cycles between eop and the next IDLE→SOP decision; sop spacing 12.

Source files
------------

// File: rtl/hydra_pkg.sv
// Shared definitions for the hydra packet generator: lane FSM states,
// header field layout and the LFSR step function.
package hydra_pkg;

    // Per-lane FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_HDR,
        ST_DATA,
        ST_EOP,
        ST_GAP
    } lane_state_e;

    // Header word layout: {len[8:0], prio[2:0], dest[3:0]}
    localparam int unsigned LEN_LSB  = 7;
    localparam int unsigned PRIO_LSB = 4;
    localparam int unsigned DEST_LSB = 0;

    // Right-shift Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // One LFSR step; the feedback bit enters at the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    // Assemble the 16-bit header word
    function automatic logic [15:0] make_hdr(input logic [8:0] len,
                                             input logic [2:0] prio,
                                             input logic [3:0] dest);
        return (16'(len) << LEN_LSB) | (16'(prio) << PRIO_LSB) | (16'(dest) << DEST_LSB);
    endfunction

endpackage

// File: rtl/hydra_pkt_gen_lane.sv
// One generator lane: FSM, LFSR, word/gap counter, sent counter and done flag.
// Ports: clk, rst_n; enable/lane_en start control; cfg_* packet configuration;
// wr_sop/wr_eop/wr_vld/wr_data registered write interface; done quota flag.
module hydra_pkt_gen_lane
    import hydra_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned LEN_MIN       = 32,
    parameter int unsigned LEN_SPAN_LOG2 = 6,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned LANE_ID       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              lane_en,
    input  logic              len_mode,
    input  logic [8:0]        cfg_len,
    input  logic              dest_mode,
    input  logic [3:0]        cfg_dest,
    input  logic [2:0]        cfg_prio,
    input  logic [3:0]        cfg_gap,
    input  logic [15:0]       cfg_pkt_num,
    output logic              wr_sop,
    output logic              wr_eop,
    output logic              wr_vld,
    output logic [DATA_W-1:0] wr_data,
    output logic              done
);

    localparam logic [15:0] SEED_X    = SEED ^ 16'(LANE_ID + 1);
    localparam logic [15:0] SEED_L    = (SEED_X == 16'd0) ? 16'd1 : SEED_X;
    localparam logic [7:0]  SPAN_MASK = 8'((1 << LEN_SPAN_LOG2) - 1);
    localparam bit          POW2      = ((NUM_PORTS & (NUM_PORTS - 1)) == 0);

    // Reduce a 4-bit value modulo NUM_PORTS
    function automatic logic [3:0] dest_of(input logic [3:0] v);
        logic [4:0] d;
        d = {1'b0, v};
        if (POW2) begin
            d = d & 5'(NUM_PORTS - 1);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (d >= 5'(NUM_PORTS)) d = d - 5'(NUM_PORTS);
            end
        end
        return d[3:0];
    endfunction

    // Payload word: lane id in the top nibble, word index in the low bits
    function automatic logic [DATA_W-1:0] data_word(input logic [8:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        w[DATA_W-1 -: 4] = 4'(LANE_ID);
        w[8:0] = idx;
        return w;
    endfunction

    lane_state_e       state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_adv;
    logic [8:0]        len_q, len_d, len_rand;
    logic [3:0]        dest_q, dest_d;
    logic [2:0]        prio_q, prio_d;
    logic [3:0]        gap_q, gap_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [15:0]       sent_q, sent_d;
    logic              done_q, done_d;
    logic              sop_d, eop_d, vld_d;
    logic [DATA_W-1:0] data_d;

    // Next-state, per-packet latches and next registered outputs
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        len_d    = len_q;
        dest_d   = dest_q;
        prio_d   = prio_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        sent_d   = sent_q;
        done_d   = done_q;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        vld_d    = 1'b0;
        data_d   = '0;
        lfsr_adv = lfsr_next(lfsr_q);
        len_rand = 9'(LEN_MIN) + 9'(lfsr_adv[15:8] & SPAN_MASK);

        case (state_q)
            ST_IDLE: begin
                if (enable && lane_en && !done_q) begin
                    state_d = ST_SOP;
                    sop_d   = 1'b1;
                end
            end
            ST_SOP: begin
                lfsr_d  = lfsr_adv;
                len_d   = len_mode ? len_rand : ((cfg_len == 9'd0) ? 9'd1 : cfg_len);
                dest_d  = dest_mode ? dest_of(lfsr_adv[3:0]) : cfg_dest;
                prio_d  = dest_mode ? lfsr_adv[6:4] : cfg_prio;
                gap_d   = cfg_gap;
                state_d = ST_HDR;
                vld_d   = 1'b1;
                data_d  = DATA_W'(make_hdr(len_d, prio_d, dest_d));
            end
            ST_HDR: begin
                state_d = ST_DATA;
                cnt_d   = 9'd0;
                vld_d   = 1'b1;
                data_d  = data_word(9'd0);
            end
            ST_DATA: begin
                if (cnt_q == len_q - 9'd1) begin
                    state_d = ST_EOP;
                    eop_d   = 1'b1;
                    // done is judged against the pre-increment count
                    if (cfg_pkt_num != 16'd0 && ({1'b0, sent_q} + 17'd1) == {1'b0, cfg_pkt_num})
                        done_d = 1'b1;
                    if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
                end else begin
                    cnt_d  = cnt_q + 9'd1;
                    vld_d  = 1'b1;
                    data_d = data_word(cnt_q + 9'd1);
                end
            end
            ST_EOP: begin
                if (gap_q != 4'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = 9'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == 9'(gap_q)) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q + 9'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_L;
            len_q   <= '0;
            dest_q  <= '0;
            prio_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            wr_vld  <= 1'b0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            len_q   <= len_d;
            dest_q  <= dest_d;
            prio_q  <= prio_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            wr_sop  <= sop_d;
            wr_eop  <= eop_d;
            wr_vld  <= vld_d;
            wr_data <= data_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/hydra_pkt_gen.sv
// Multi-port packet traffic generator for the hydra ingress interface.
// Ports: clk, rst_n; enable, port_mask run control; len/dest/prio/gap/pkt_num
// configuration shared by all lanes; per-lane wr_sop/wr_eop/wr_vld, packed
// wr_data (lane p at [p*DATA_W +: DATA_W]) and done.
module hydra_pkt_gen
    import hydra_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned LEN_MIN       = 32,
    parameter int unsigned LEN_SPAN_LOG2 = 6,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_PORTS-1:0]        port_mask,
    input  logic                        len_mode,
    input  logic [8:0]                  cfg_len,
    input  logic                        dest_mode,
    input  logic [3:0]                  cfg_dest,
    input  logic [2:0]                  cfg_prio,
    input  logic [3:0]                  cfg_gap,
    input  logic [15:0]                 cfg_pkt_num,
    output logic [NUM_PORTS-1:0]        wr_sop,
    output logic [NUM_PORTS-1:0]        wr_eop,
    output logic [NUM_PORTS-1:0]        wr_vld,
    output logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic [NUM_PORTS-1:0]        done
);

    // One independent lane per ingress port
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
        hydra_pkt_gen_lane #(
            .NUM_PORTS     (NUM_PORTS),
            .DATA_W        (DATA_W),
            .LEN_MIN       (LEN_MIN),
            .LEN_SPAN_LOG2 (LEN_SPAN_LOG2),
            .SEED          (SEED),
            .LANE_ID       (p)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .lane_en     (port_mask[p]),
            .len_mode    (len_mode),
            .cfg_len     (cfg_len),
            .dest_mode   (dest_mode),
            .cfg_dest    (cfg_dest),
            .cfg_prio    (cfg_prio),
            .cfg_gap     (cfg_gap),
            .cfg_pkt_num (cfg_pkt_num),
            .wr_sop      (wr_sop[p]),
            .wr_eop      (wr_eop[p]),
            .wr_vld      (wr_vld[p]),
            .wr_data     (wr_data[p*DATA_W +: DATA_W]),
            .done        (done[p])
        );
    end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// Directed scoreboard bench for hydra_pkt_gen (default parameters).
// Lane 0 is checked word-by-word against a reference packet queue; all lanes
// are checked for protocol rules and sop/eop counts.
module tb_hydra_pkt_gen;

    localparam int NP = 16;
    localparam int DW = 16;
    localparam logic [15:0] SEED0 = 16'hACE1 ^ 16'h0001;
    localparam logic [1:0] K_SOP = 2'd0, K_VLD = 2'd1, K_EOP = 2'd2, K_NONE = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [NP-1:0]    port_mask = '0;
    logic             len_mode = 1'b0;
    logic [8:0]       cfg_len = 9'd0;
    logic             dest_mode = 1'b0;
    logic [3:0]       cfg_dest = 4'd0;
    logic [2:0]       cfg_prio = 3'd0;
    logic [3:0]       cfg_gap = 4'd0;
    logic [15:0]      cfg_pkt_num = 16'd0;
    logic [NP-1:0]    wr_sop, wr_eop, wr_vld, done;
    logic [NP*DW-1:0] wr_data;

    hydra_pkt_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .port_mask(port_mask),
        .len_mode(len_mode), .cfg_len(cfg_len), .dest_mode(dest_mode),
        .cfg_dest(cfg_dest), .cfg_prio(cfg_prio), .cfg_gap(cfg_gap),
        .cfg_pkt_num(cfg_pkt_num), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_vld(wr_vld), .wr_data(wr_data), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr = SEED0;

    int          cyc = 0;
    int          last_sop = -1;
    int          exp_spacing = 0;
    int          vcount = 0;
    bit          in_pkt = 0;
    bit          rand_chk = 0;
    logic [15:0] hdr = '0;
    int          sop_cnt[NP];
    int          eop_cnt[NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_ev(input logic [1:0] kind, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Reference for one lane-0 packet; the LFSR advances every packet
    task automatic gen_pkt(input bit lm, input logic [8:0] clen, input bit dm,
                           input logic [3:0] cdest, input logic [2:0] cprio);
        logic [8:0] len;
        logic [3:0] dest;
        logic [2:0] prio;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        len  = lm ? 9'(32 + int'(m_lfsr[13:8])) : ((clen == 9'd0) ? 9'd1 : clen);
        dest = dm ? m_lfsr[3:0] : cdest;
        prio = dm ? m_lfsr[6:4] : cprio;
        push_ev(K_SOP, 16'h0000);
        push_ev(K_VLD, {len, prio, dest});
        for (int i = 0; i < int'(len); i++) push_ev(K_VLD, {4'h0, 3'b000, 9'(i)});
        push_ev(K_EOP, 16'h0000);
    endtask

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_sop = -1;
            in_pkt = 0;
            vcount = 0;
            for (int p = 0; p < NP; p++) begin
                sop_cnt[p] = 0;
                eop_cnt[p] = 0;
            end
        end else begin
            logic       proto_ok;
            logic [1:0] kind;
            ev_t        e;
            cyc++;
            proto_ok = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if ((int'(wr_sop[p]) + int'(wr_vld[p]) + int'(wr_eop[p])) > 1) proto_ok = 1'b0;
                if (!wr_vld[p] && wr_data[p*DW +: DW] != '0) proto_ok = 1'b0;
                sop_cnt[p] += int'(wr_sop[p]);
                eop_cnt[p] += int'(wr_eop[p]);
            end
            chk("protocol", 32'(proto_ok), 32'd1);

            if (wr_sop[0] || wr_vld[0] || wr_eop[0]) begin
                kind = wr_sop[0] ? K_SOP : (wr_eop[0] ? K_EOP : K_VLD);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(kind), 32'(K_NONE));
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(kind), 32'(e.kind));
                    chk("event_word", 32'(wr_data[15:0]), 32'(e.data));
                end
            end

            if (wr_sop[0]) begin
                if (exp_spacing != 0 && last_sop >= 0)
                    chk("sop_spacing", 32'(cyc - last_sop), 32'(exp_spacing));
                last_sop = cyc;
                in_pkt = 1;
                vcount = 0;
            end else if (in_pkt) begin
                chk("contiguous", 32'(wr_vld[0] | wr_eop[0]), 32'd1);
                if (wr_vld[0]) begin
                    if (vcount == 0) hdr = wr_data[15:0];
                    vcount++;
                end
                if (wr_eop[0]) begin
                    chk("len_vs_vld", 32'(vcount), 32'(hdr[15:7]) + 32'd1);
                    if (rand_chk)
                        chk("len_range", 32'(hdr[15:7] >= 9'd32 && hdr[15:7] <= 9'd95), 32'd1);
                    in_pkt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        m_lfsr = SEED0;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input logic [15:0] mask, input int budget, input string tag);
        int i;
        i = 0;
        while (done !== mask && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(done), 32'(mask));
    endtask

    task automatic wait_sop0(input int budget, input string tag);
        int i;
        i = 0;
        while (wr_sop[0] !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(wr_sop[0]), 32'd1);
    endtask

    initial begin
        // Reset values while rst_n is held low
        #1;
        chk("rst_sop", 32'(wr_sop), 32'd0);
        chk("rst_vld", 32'(wr_vld), 32'd0);
        chk("rst_eop", 32'(wr_eop), 32'd0);
        chk("rst_data_lo", wr_data[31:0], 32'd0);
        chk("rst_data_hi", wr_data[NP*DW-1 -: 32], 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Fixed mode, lane 0: header 0x1035, 32 words, spacing 36
        do_reset();
        len_mode = 0; cfg_len = 9'd32; dest_mode = 0; cfg_dest = 4'd5; cfg_prio = 3'd3;
        cfg_gap = 4'd0; cfg_pkt_num = 16'd2; port_mask = 16'h0001; exp_spacing = 36;
        gen_pkt(0, 9'd32, 0, 4'd5, 3'd3);
        gen_pkt(0, 9'd32, 0, 4'd5, 3'd3);
        enable = 1;
        wait_done(16'h0001, 200, "t1_done");
        repeat (10) @(negedge clk);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_sop_count", 32'(sop_cnt[0]), 32'd2);

        // Packet quota of 3 on all lanes
        enable = 0;
        do_reset();
        cfg_len = 9'd8; cfg_gap = 4'd1; cfg_pkt_num = 16'd3; port_mask = 16'hFFFF;
        exp_spacing = 13;
        for (int k = 0; k < 3; k++) gen_pkt(0, 9'd8, 0, 4'd5, 3'd3);
        enable = 1;
        wait_done(16'hFFFF, 500, "t2_done");
        repeat (100) @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("t2_sop_l%0d", p), 32'(sop_cnt[p]), 32'd3);
            chk($sformatf("t2_eop_l%0d", p), 32'(eop_cnt[p]), 32'd3);
        end
        chk("t2_done_sticky", 32'(done), 32'hFFFF);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random length/dest/prio, 200 packets on lane 0
        enable = 0;
        do_reset();
        len_mode = 1; dest_mode = 1; cfg_gap = 4'd0; cfg_pkt_num = 16'd200;
        port_mask = 16'h0001; exp_spacing = 0; rand_chk = 1;
        for (int k = 0; k < 200; k++) gen_pkt(1, 9'd0, 1, 4'd0, 3'd0);
        enable = 1;
        wait_done(16'h0001, 25000, "t3_done");
        repeat (10) @(negedge clk);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t3_sop_count", 32'(sop_cnt[0]), 32'd200);
        rand_chk = 0;

        // Enable dropped two cycles after sop: packet still completes
        enable = 0;
        do_reset();
        len_mode = 0; dest_mode = 0; cfg_len = 9'd40; cfg_dest = 4'd2; cfg_prio = 3'd1;
        cfg_pkt_num = 16'd0;
        gen_pkt(0, 9'd40, 0, 4'd2, 3'd1);
        enable = 1;
        wait_sop0(20, "t4_first_sop");
        repeat (2) @(posedge clk);
        #1 enable = 0;
        repeat (80) @(negedge clk);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_sop_count", 32'(sop_cnt[0]), 32'd1);
        chk("t4_eop_count", 32'(eop_cnt[0]), 32'd1);
        cfg_pkt_num = 16'd2;
        gen_pkt(0, 9'd40, 0, 4'd2, 3'd1);
        enable = 1;
        wait_done(16'h0001, 200, "t4_resume_done");
        repeat (10) @(negedge clk);
        chk("t4_resume_sops", 32'(sop_cnt[0]), 32'd2);
        chk("t4_resume_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-DATA, then first packet from fresh seed
        enable = 0;
        do_reset();
        cfg_len = 9'd32; cfg_pkt_num = 16'd0;
        gen_pkt(0, 9'd32, 0, 4'd2, 3'd1);
        enable = 1;
        wait_sop0(20, "t5_sop");
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t5_async_vld", 32'(wr_vld), 32'd0);
        chk("t5_async_sop", 32'(wr_sop), 32'd0);
        chk("t5_async_eop", 32'(wr_eop), 32'd0);
        chk("t5_async_data", wr_data[31:0], 32'd0);
        len_mode = 1; dest_mode = 1; cfg_pkt_num = 16'd1;
        do_reset();
        gen_pkt(1, 9'd0, 1, 4'd0, 3'd0);
        wait_done(16'h0001, 300, "t5_done");
        repeat (10) @(negedge clk);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // cfg_len=0 acts as 1, gap 7: spacing 12
        enable = 0;
        do_reset();
        len_mode = 0; dest_mode = 0; cfg_len = 9'd0; cfg_gap = 4'd7; cfg_pkt_num = 16'd3;
        cfg_dest = 4'd9; cfg_prio = 3'd6; exp_spacing = 12;
        for (int k = 0; k < 3; k++) gen_pkt(0, 9'd0, 0, 4'd9, 3'd6);
        enable = 1;
        wait_done(16'h0001, 200, "t6_done");
        repeat (20) @(negedge clk);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_sop_count", 32'(sop_cnt[0]), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
